// File: rtl/score_bus_generator_pkg.sv
// Shared types and constants for the score bus producer.
package score_bus_generator_pkg;

    localparam int unsigned SCORE_W       = 7;
    localparam int unsigned SCORE_MAX_DEF = 100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } stateT;

endpackage

// File: rtl/score_bus_generator_channel.sv
// One saturating score counter; an increment and a decrement in the same cycle cancel out.
module score_channel
    import score_bus_generator_pkg::*;
#(
    parameter int unsigned SCORE_MAX = SCORE_MAX_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               inc,
    input  logic               dec,
    output logic [SCORE_W-1:0] score
);

    logic [SCORE_W-1:0] scoreQ, scoreD;

    always_comb begin
        scoreD = scoreQ;
        if (clear) begin
            scoreD = '0;
        end else if (enable) begin
            // Limits are checked before the add/subtract, so no carry or borrow escapes.
            case ({inc, dec})
                2'b10: if (scoreQ < SCORE_W'(SCORE_MAX)) scoreD = scoreQ + SCORE_W'(1);
                2'b01: if (scoreQ != '0) scoreD = scoreQ - SCORE_W'(1);
                default: scoreD = scoreQ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            scoreQ <= '0;
        end else begin
            scoreQ <= scoreD;
        end
    end

    assign score = scoreQ;

endmodule

// File: rtl/score_bus_generator.sv
// Timed scoring rounds with a valid/ack handoff of four frozen score buses.
// Optional decay of all channels is built only when SCORE_DECAY_EN is defined.
module score_bus_generator
    import score_bus_generator_pkg::*;
#(
    parameter int unsigned ROUND_CYCLES = 1000,
    parameter int unsigned SCORE_MAX    = SCORE_MAX_DEF,
    parameter int unsigned DECAY_PERIOD = 64
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [3:0]         Inc,
    input  logic               Ack,
    output logic [SCORE_W-1:0] BusA,
    output logic [SCORE_W-1:0] BusB,
    output logic [SCORE_W-1:0] BusC,
    output logic [SCORE_W-1:0] BusD,
    output logic               Valid,
    output logic               Busy
);

    localparam int unsigned TIMER_W = $clog2(ROUND_CYCLES + 1);

    stateT              stateQ, stateD;
    logic [TIMER_W-1:0] timerQ, timerD;
    logic               startRound;
    logic               runStep;
    logic               decayStep;
    logic [SCORE_W-1:0] score [4];

    assign startRound = (stateQ == IDLE) && Start;
    assign runStep    = (stateQ == RUN);

    always_comb begin
        stateD = stateQ;
        timerD = timerQ;
        case (stateQ)
            IDLE: begin
                if (Start) begin
                    stateD = RUN;
                    timerD = TIMER_W'(ROUND_CYCLES);
                end
            end
            RUN: begin
                timerD = timerQ - TIMER_W'(1);
                if (timerQ == TIMER_W'(1)) stateD = HOLD;
            end
            HOLD: begin
                if (Ack) stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ <= IDLE;
            timerQ <= '0;
        end else begin
            stateQ <= stateD;
            timerQ <= timerD;
        end
    end

`ifdef SCORE_DECAY_EN
    localparam int unsigned DECAY_W = $clog2(DECAY_PERIOD + 1);

    logic [DECAY_W-1:0] decayQ;

    assign decayStep = runStep && (decayQ == DECAY_W'(DECAY_PERIOD - 1));

    always_ff @(posedge Clock) begin
        if (Reset || startRound) begin
            decayQ <= '0;
        end else if (runStep) begin
            decayQ <= decayStep ? '0 : decayQ + DECAY_W'(1);
        end
    end
`else
    // DECAY_PERIOD has no effect without decay.
    assign decayStep = 1'b0 && (DECAY_PERIOD == 0);
`endif

    for (genvar i = 0; i < 4; i++) begin : gChan
        score_channel #(
            .SCORE_MAX(SCORE_MAX)
        ) uChan (
            .Clock (Clock),
            .Reset (Reset),
            .clear (startRound),
            .enable(runStep),
            .inc   (Inc[i]),
            .dec   (decayStep),
            .score (score[i])
        );
    end

    assign BusA  = score[0];
    assign BusB  = score[1];
    assign BusC  = score[2];
    assign BusD  = score[3];
    assign Valid = (stateQ == HOLD);
    assign Busy  = (stateQ == RUN);

endmodule
